// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the main-memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam int CTR_W_DEFAULT = 8;

endpackage

// File: rtl/arb_wait_ctr.sv
// rtl/arb_wait_ctr.sv - loadable wait-state down-counter with completion flag
module arb_wait_ctr
    import mem_arb_pkg::*;
#(
    parameter int CTR_W = CTR_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CTR_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [CTR_W-1:0] count_q, count_d;
    logic             zero_q, zero_d;

    // Load has priority over decrement; the counter never wraps below zero.
    always_comb begin
        count_d = count_q;
        zero_d  = zero_q;
        if (load_i) begin
            count_d = load_val_i;
            zero_d  = (load_val_i == '0);
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CTR_W'(1);
        end
    end

    // Counter and zero-load flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            zero_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

    // Done on the last counted cycle, or immediately when a zero was loaded.
    assign done_o = (count_q == CTR_W'(1)) | zero_q;

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester main-memory arbiter/sequencer; MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = 4,
    parameter int CTR_W       = CTR_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic Req0Strobe,
    input  logic Req0RW,
    input  logic Req1Strobe,
    input  logic Req1RW,
    output logic Req0Ready,
    output logic Req1Ready,
    output logic MStrobe,
    output logic MRW,
    output logic MSel,
    output logic Busy
);

    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > (2 ** CTR_W) - 1)) begin : g_wait_range
        $error("mem_arbiter: WAIT_CYCLES does not fit in the CTR_W-bit wait counter");
    end

    localparam logic [CTR_W-1:0] WAIT_LOAD = CTR_W'(WAIT_CYCLES);

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;
    logic       rw_q, rw_d;
    logic       ctr_load;
    logic       ctr_dec;
    logic       ctr_done;
    logic       tie_owner;
    logic       busy;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Alternate on ties: the requester that did not own the port last wins.
    assign tie_owner = ~last_owner_q;
`else
    // Fixed priority: the data cache always wins ties.
    assign tie_owner = 1'b0;
`endif

    arb_wait_ctr #(
        .CTR_W (CTR_W)
    ) u_wait_ctr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ctr_load),
        .load_val_i (WAIT_LOAD),
        .dec_i      (ctr_dec),
        .done_o     (ctr_done)
    );

    // Next-state logic: grant in IDLE, strobe once, wait out the memory, then acknowledge.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rw_d         = rw_q;
        ctr_load     = 1'b0;
        ctr_dec      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Req0Strobe && Req1Strobe) begin
                    owner_d = tie_owner;
                    rw_d    = tie_owner ? Req1RW : Req0RW;
                    state_d = ISSUE;
                end else if (Req0Strobe) begin
                    owner_d = 1'b0;
                    rw_d    = Req0RW;
                    state_d = ISSUE;
                end else if (Req1Strobe) begin
                    owner_d = 1'b1;
                    rw_d    = Req1RW;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                ctr_load = 1'b1;
                state_d  = (WAIT_CYCLES == 0) ? DONE : WAIT;
            end
            WAIT: begin
                ctr_dec = 1'b1;
                if (ctr_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and grant registers; reset parks the port with requester 1 as last owner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            rw_q         <= WRITE;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rw_q         <= rw_d;
        end
    end

    // Moore outputs; everything is gated by busy so IDLE drives all zeros.
    assign busy      = (state_q != IDLE);
    assign Busy      = busy;
    assign MStrobe   = (state_q == ISSUE);
    assign MRW       = busy & rw_q;
    assign MSel      = busy & owner_q;
    assign Req0Ready = (state_q == DONE) & ~owner_q;
    assign Req1Ready = (state_q == DONE) & owner_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the shared main-memory port.
- Requester 0 is the data-cache controller; requester 1 is the instruction-cache controller.
- Grants one requester at a time, issues a single-cycle MStrobe with latched MRW, counts memory wait states, and returns a one-cycle Ready pulse to the owner.
- Sits between the cache controllers and the memory model; drives the memory address/data mux select.

Parameters:
- WAIT_CYCLES, 4, memory wait states per access, 0..255.
- CTR_W, 8, width of the wait-state counter.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous active-low reset.
- Req0Strobe, input, 1, requester 0 access request (level).
- Req0RW, input, 1, requester 0 direction: 1 = read, 0 = write.
- Req1Strobe, input, 1, requester 1 access request (level).
- Req1RW, input, 1, requester 1 direction: 1 = read, 0 = write.
- Req0Ready, output, 1, one-cycle completion pulse to requester 0.
- Req1Ready, output, 1, one-cycle completion pulse to requester 1.
- MStrobe, output, 1, memory access strobe.
- MRW, output, 1, memory direction (latched RW of the owner).
- MSel, output, 1, owner index; drives the address/data mux.
- Busy, output, 1, high while any transaction is in flight.

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is asynchronous and active-low. While reset is low: state = IDLE, counter = 0, owner = 0, last_owner = 1, rw_q = 0, and every output is 0.
- States: IDLE, ISSUE, WAIT, DONE. Outputs are Moore-decoded from state and registers.
- Request protocol: each requester holds Strobe and RW stable from assertion until its Ready pulse. The arbiter samples RW only at grant.
- IDLE:
  - No strobe: stay in IDLE.
  - One strobe: owner <= that requester, rw_q <= its RW, go to ISSUE.
  - Both strobes: arbitrate per Optional Feature.
- ISSUE (1 cycle): MStrobe=1; counter <= WAIT_CYCLES. Go to DONE if WAIT_CYCLES==0, else to WAIT.
- WAIT: lasts exactly WAIT_CYCLES cycles. Counter decrements each cycle; go to DONE when counter==1.
- DONE (1 cycle): Ready of the owner = 1, the other Ready = 0; last_owner <= owner; go to IDLE.
- MRW = rw_q, MSel = owner, and Busy = 1 in ISSUE, WAIT and DONE. All three are 0 in IDLE.
- Latency: strobe sampled in IDLE at cycle t gives MStrobe at t+1 and Ready at t+2+WAIT_CYCLES. Back-to-back grants are separated by one IDLE cycle.
- A strobe still high in the cycle after DONE is treated as a new request.
- Input changes during ISSUE/WAIT/DONE are ignored, including RW toggles and the non-owner's strobe. Pending requests wait in IDLE; none are dropped.
- Reset mid-operation: all outputs clear immediately (asynchronously). No Ready is issued for the aborted access; requesters reissue after reset release.
- Counter width: WAIT_CYCLES > 2^CTR_W - 1 is illegal and is flagged by an elaboration-time assertion.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests in IDLE, grant the requester that is not last_owner. First tie after reset goes to requester 0.
- Undefined: fixed priority, requester 0 always wins ties; last_owner is still maintained but unused.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] arb_state_t {IDLE, ISSUE, WAIT, DONE};
  - localparam READ = 1'b1, WRITE = 1'b0;
  - default CTR_W.
- Sub-module arb_wait_ctr: loadable down-counter with load, load value, and done flag (count==1 or loaded 0). Uses the same clk and asynchronous active-low reset.

Test Plan:
- WAIT_CYCLES=4, Req0Strobe=1, Req0RW=1 at cycle 0 → MStrobe=1, MRW=1, MSel=0 at cycle 1 only; Busy cycles 1–6; Req0Ready=1 at cycle 6 only; Req1Ready stays 0.
- Both strobes at cycle 0 after reset (Req1RW=0) → requester 0 Ready at cycle 6; MStrobe=1, MSel=1, MRW=0 at cycle 8; Req1Ready at cycle 13.
- Both strobes held continuously for three grants → with MEM_ARB_ROUND_ROBIN_EN, grant order 0,1,0; without it, 0,0,0.
- Req0 write grant, then Req0RW toggled during WAIT (cycle 3) → MRW stays 0 through cycle 6.
- reset driven low at cycle 3 of a Req0 access → MStrobe/MSel/MRW/Busy/Ready all 0 within the same cycle, no Ready pulse. After release, a reissued request completes with full W+2 latency.
- WAIT_CYCLES=0, Req1Strobe at cycle 0 → MStrobe at cycle 1, Req1Ready at cycle 2.
